// File: rtl/preg_alloc_ctrl_if.sv
// Bundle of rename-side, commit-side and free-list FIFO signals for the
// physical-register allocation controller.
interface preg_alloc_ctrl_if #(
  parameter int MAX_LENGTH = 64,
  parameter int PREG_BITS  = 6,
  parameter int MAX_IO     = 3,
  parameter int CNT_BITS   = 16
);
  localparam int LEN_BITS = $clog2(MAX_LENGTH) + 1;

  logic [MAX_IO-1:0]                 req_valid;
  logic                              req_ready;
  logic                              alloc_valid;
  logic [MAX_IO-1:0]                 alloc_lane_valid;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  alloc_preg;
  logic                              alloc_ready;
  logic [MAX_IO-1:0]                 free_valid;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  free_preg;
  logic                              free_ready;
  logic                              flush;
  logic                              fl_rst;
  logic [MAX_IO-1:0]                 fl_get_en;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  fl_gotten;
  logic [MAX_IO-1:0]                 fl_put_en;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  fl_put;
  logic [LEN_BITS-1:0]               fl_len;
  logic [CNT_BITS-1:0]               stall_cnt;

  modport master (
    input  req_valid, alloc_ready, free_valid, free_preg, flush, fl_gotten, fl_len,
    output req_ready, alloc_valid, alloc_lane_valid, alloc_preg, free_ready,
           fl_rst, fl_get_en, fl_put_en, fl_put, stall_cnt
  );

  modport slave (
    output req_valid, alloc_ready, free_valid, free_preg, flush, fl_gotten, fl_len,
    input  req_ready, alloc_valid, alloc_lane_valid, alloc_preg, free_ready,
           fl_rst, fl_get_en, fl_put_en, fl_put, stall_cnt
  );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// Sequences the multi-port physical-register free-list FIFO: init, all-or-nothing
// allocation into a one-deep output stage, guarded frees and flush give-back.
module preg_alloc_ctrl #(
  parameter int MAX_LENGTH = 64,
  parameter int PREG_BITS  = 6,
  parameter int MAX_IO     = 3,
  parameter int CNT_BITS   = 16
) (
  input logic                clk,
  input logic                rst,
  preg_alloc_ctrl_if.master  bus
);
  localparam int LEN_BITS = $clog2(MAX_LENGTH) + 1;
  localparam logic [LEN_BITS:0] LEN_LIMIT = (LEN_BITS+1)'(MAX_LENGTH);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_WARM   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  logic [1:0]                        state;
  logic [LEN_BITS-1:0]               nreq;
  logic [LEN_BITS-1:0]               nfree;
  logic                              in_run;
  logic                              grant;
  logic                              free_ok;
  logic                              hold_flush;
  logic                              alloc_valid_q;
  logic [MAX_IO-1:0]                 lane_valid_q;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  preg_q;
  logic [MAX_IO-1:0]                 ret_valid;
  logic [MAX_IO-1:0][PREG_BITS-1:0]  ret_preg;
  logic [CNT_BITS-1:0]               stall_q;

  function automatic logic [LEN_BITS-1:0] popcount(input logic [MAX_IO-1:0] v);
    logic [LEN_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_IO; i++) n = n + LEN_BITS'(v[i]);
    return n;
  endfunction

  // A group is granted whole or not at all; the free guard is strict to match the FIFO's own put guard.
  always_comb begin
    in_run     = (state == S_RUN);
    nreq       = popcount(bus.req_valid);
    nfree      = popcount(bus.free_valid);
    grant      = in_run && !bus.flush && (nreq != '0) && (nreq <= bus.fl_len) &&
                 (!alloc_valid_q || bus.alloc_ready);
    free_ok    = in_run && !bus.flush && (nfree != '0) &&
                 (({1'b0, bus.fl_len} + {1'b0, nfree}) < LEN_LIMIT);
    hold_flush = in_run && bus.flush && alloc_valid_q && !bus.alloc_ready;
  end

  assign bus.fl_rst           = !rst || (state == S_INIT);
  assign bus.req_ready        = grant;
  assign bus.fl_get_en        = grant ? bus.req_valid : '0;
  assign bus.free_ready       = free_ok;
  assign bus.fl_put_en        = (state == S_RETURN) ? ret_valid : (free_ok ? bus.free_valid : '0);
  assign bus.fl_put           = (state == S_RETURN) ? ret_preg : bus.free_preg;
  assign bus.alloc_valid      = alloc_valid_q;
  assign bus.alloc_lane_valid = lane_valid_q;
  assign bus.alloc_preg       = preg_q;
  assign bus.stall_cnt        = stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_INIT;
      alloc_valid_q <= 1'b0;
      lane_valid_q  <= '0;
      preg_q        <= '0;
      ret_valid     <= '0;
      ret_preg      <= '0;
      stall_q       <= '0;
    end else begin
      case (state)
        S_INIT:  state <= S_WARM;
        S_WARM:  state <= S_RUN;
        S_RUN:   if (hold_flush) state <= S_RETURN;
        default: state <= S_RUN;
      endcase

      if (grant) begin
        alloc_valid_q <= 1'b1;
        lane_valid_q  <= bus.req_valid;
        for (int i = 0; i < MAX_IO; i++)
          preg_q[i] <= bus.req_valid[i] ? bus.fl_gotten[i] : '0;
      end else if ((in_run && bus.flush) || bus.alloc_ready) begin
        alloc_valid_q <= 1'b0;
      end

      // An unconsumed group caught by a flush is parked here and re-put next cycle.
      if (hold_flush) begin
        ret_valid <= lane_valid_q;
        ret_preg  <= preg_q;
      end

      if (in_run && (nreq != '0) && !grant && (stall_q != '1))
        stall_q <= stall_q + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl: behavioural free-list FIFO, vector table with a
// reference free-list queue and a scoreboard of expected allocation groups.
module tb_preg_alloc_ctrl;
  localparam int MAX_LENGTH = 64;
  localparam int PREG_BITS  = 6;
  localparam int MAX_IO     = 3;
  localparam int CNT_BITS   = 16;

  typedef logic [MAX_IO-1:0][PREG_BITS-1:0] pregs_t;

  typedef struct {
    logic [MAX_IO-1:0] rv;
    logic              ar;
    logic [MAX_IO-1:0] fv;
    pregs_t            fp;
    logic              fl;
    logic              e_rr;
    logic              e_fr;
    logic              e_av;
  } vec_t;

  typedef struct {
    logic [MAX_IO-1:0] lv;
    pregs_t            p;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  preg_alloc_ctrl_if #(.MAX_LENGTH(MAX_LENGTH), .PREG_BITS(PREG_BITS),
                       .MAX_IO(MAX_IO), .CNT_BITS(CNT_BITS)) bus();

  preg_alloc_ctrl #(.MAX_LENGTH(MAX_LENGTH), .PREG_BITS(PREG_BITS),
                    .MAX_IO(MAX_IO), .CNT_BITS(CNT_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural free-list FIFO: enabled lanes are compacted in lane order.
  logic [PREG_BITS-1:0] mem [MAX_LENGTH];
  logic [5:0]           head;
  logic [6:0]           cnt;
  logic [6:0]           ngets;
  logic [6:0]           nputs;
  logic [5:0]           put_off [MAX_IO];
  logic                 get_ok;
  logic                 put_ok;

  always_comb begin
    ngets = '0;
    nputs = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      put_off[i]       = nputs[5:0];
      bus.fl_gotten[i] = mem[head + ngets[5:0]];
      if (bus.fl_get_en[i]) ngets = ngets + 7'd1;
      if (bus.fl_put_en[i]) nputs = nputs + 7'd1;
    end
    get_ok = (ngets <= cnt);
    put_ok = ((cnt + nputs) < 7'd64);
  end

  assign bus.fl_len = cnt;

  always @(posedge clk) begin
    if (bus.fl_rst) begin
      for (int i = 0; i < MAX_LENGTH; i++) mem[i] <= 6'(i);
      head <= '0;
      cnt  <= 7'd64;
    end else begin
      if (get_ok) head <= head + ngets[5:0];
      if (put_ok)
        for (int i = 0; i < MAX_IO; i++)
          if (bus.fl_put_en[i]) mem[head + cnt[5:0] + put_off[i]] <= bus.fl_put[i];
      cnt <= cnt - (get_ok ? ngets : 7'd0) + (put_ok ? nputs : 7'd0);
    end
  end

  int   vectors    = 0;
  int   miscompares = 0;
  int   ref_fl [$];
  grp_t exp_q [$];
  grp_t held;
  grp_t ret_grp;
  logic grant_prev;
  logic ret_pend;
  int   exp_stall;
  vec_t tbl [$];

  function automatic pregs_t pg(input int a, input int b, input int c);
    pregs_t p;
    p[0] = 6'(a);
    p[1] = 6'(b);
    p[2] = 6'(c);
    return p;
  endfunction

  function automatic vec_t mk(input logic [2:0] rv, input logic ar, input logic [2:0] fv,
                              input pregs_t fp, input logic fl, input logic e_rr,
                              input logic e_fr, input logic e_av);
    vec_t v;
    v.rv = rv; v.ar = ar; v.fv = fv; v.fp = fp; v.fl = fl;
    v.e_rr = e_rr; v.e_fr = e_fr; v.e_av = e_av;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One table row is one clock: drive, compare, then advance the reference model.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.req_valid   = v.rv;
    bus.alloc_ready = v.ar;
    bus.free_valid  = v.fv;
    bus.free_preg   = v.fp;
    bus.flush       = v.fl;
    #2;
    if (grant_prev) begin
      if (exp_q.size() == 0) checkOutput("scoreboard_empty", 32'd1, 32'd0);
      else held = exp_q.pop_front();
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(v.e_rr));
    checkOutput("free_ready", 32'(bus.free_ready), 32'(v.e_fr));
    checkOutput("alloc_valid", 32'(bus.alloc_valid), 32'(v.e_av));
    if (v.e_av) begin
      checkOutput("alloc_lane_valid", 32'(bus.alloc_lane_valid), 32'(held.lv));
      checkOutput("alloc_preg", 32'(bus.alloc_preg), 32'(held.p));
    end
    checkOutput("fl_len", 32'(bus.fl_len), 32'(ref_fl.size()));
    checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));

    if (ret_pend) begin
      for (int i = 0; i < MAX_IO; i++) if (ret_grp.lv[i]) ref_fl.push_back(int'(ret_grp.p[i]));
      ret_pend = 1'b0;
    end
    if (v.e_rr) begin
      grp_t g;
      g.lv = v.rv;
      g.p  = '0;
      for (int i = 0; i < MAX_IO; i++) if (v.rv[i]) g.p[i] = 6'(ref_fl.pop_front());
      exp_q.push_back(g);
    end
    if (v.e_fr)
      for (int i = 0; i < MAX_IO; i++) if (v.fv[i]) ref_fl.push_back(int'(v.fp[i]));
    if (v.fl && v.e_av && !v.ar) begin
      ret_grp  = held;
      ret_pend = 1'b1;
    end
    if ((v.rv != '0) && !v.e_rr) exp_stall++;
    grant_prev = v.e_rr;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid   = 3'b111;
    bus.alloc_ready = 1'b0;
    bus.free_valid  = '0;
    bus.free_preg   = '0;
    bus.flush       = 1'b0;
    grant_prev      = 1'b0;
    ret_pend        = 1'b0;
    exp_stall       = 0;
    held.lv         = '0;
    held.p          = '0;
    for (int i = 0; i < MAX_LENGTH; i++) ref_fl.push_back(i);

    tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0),  0, 1, 0, 1));
    tbl.push_back(mk(3'b101, 1, 3'b000, pg(0,0,0),  0, 1, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(3'b101, 0, 3'b000, pg(0,0,0), 0, 0, 0, 1));
    tbl.push_back(mk(3'b101, 1, 3'b000, pg(0,0,0),  0, 1, 0, 1));
    tbl.push_back(mk(3'b000, 1, 3'b000, pg(0,0,0),  0, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 3'b111, pg(0,1,2),  0, 0, 1, 0));
    tbl.push_back(mk(3'b000, 0, 3'b111, pg(3,4,5),  0, 0, 1, 0));
    tbl.push_back(mk(3'b000, 0, 3'b011, pg(6,8,0),  0, 0, 1, 0));
    tbl.push_back(mk(3'b000, 0, 3'b011, pg(7,9,0),  0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 1, 3'b011, pg(7,9,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b000, 1, 3'b011, pg(7,9,0),  0, 0, 1, 1));
    tbl.push_back(mk(3'b000, 1, 3'b000, pg(0,0,0),  0, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0), 0, 1, 0, k != 0));
    tbl.push_back(mk(3'b001, 1, 3'b000, pg(0,0,0),  0, 1, 0, 1));
    tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0),  0, 0, 0, 1));
    tbl.push_back(mk(3'b011, 1, 3'b000, pg(0,0,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b001, 1, 3'b000, pg(0,0,0),  0, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 3'b111, pg(20,21,22), 0, 0, 1, 0));
    tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b000, 0, 3'b000, pg(0,0,0),  1, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 3'b001, pg(30,0,0), 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 1, 3'b000, pg(0,0,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b000, 1, 3'b011, pg(40,41,0), 0, 0, 1, 1));
    tbl.push_back(mk(3'b011, 1, 3'b000, pg(0,0,0),  0, 1, 0, 0));
    tbl.push_back(mk(3'b011, 1, 3'b000, pg(0,0,0),  1, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 3'b001, pg(50,0,0), 0, 0, 1, 0));
    tbl.push_back(mk(3'b000, 0, 3'b000, pg(0,0,0),  0, 0, 0, 0));

    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_fl_rst", 32'(bus.fl_rst), 32'd1);
    checkOutput("rst_alloc_valid", 32'(bus.alloc_valid), 32'd0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #2;
    checkOutput("init_fl_rst", 32'(bus.fl_rst), 32'd1);
    @(negedge clk);
    bus.req_valid = 3'b111;
    #2;
    checkOutput("warm_fl_rst", 32'(bus.fl_rst), 32'd0);
    checkOutput("warm_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("warm_fl_len", 32'(bus.fl_len), 32'd64);

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Reset while a granted group is still held must drop it and rebuild the list.
    @(negedge clk);
    bus.req_valid = 3'b001; bus.alloc_ready = 1'b0; bus.free_valid = '0; bus.flush = 1'b0;
    #2;
    checkOutput("mid_grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
    #2;
    checkOutput("mid_rst_held", 32'(bus.alloc_valid), 32'd1);
    checkOutput("mid_rst_fl_rst", 32'(bus.fl_rst), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("mid_init_alloc_valid", 32'(bus.alloc_valid), 32'd0);
    checkOutput("mid_init_fl_rst", 32'(bus.fl_rst), 32'd1);
    checkOutput("mid_init_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    bus.req_valid = 3'b111; bus.alloc_ready = 1'b1;
    #2;
    checkOutput("mid_warm_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mid_warm_fl_len", 32'(bus.fl_len), 32'd64);
    @(negedge clk);
    #2;
    checkOutput("mid_run_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    #2;
    checkOutput("mid_alloc_valid", 32'(bus.alloc_valid), 32'd1);
    checkOutput("mid_alloc_lane_valid", 32'(bus.alloc_lane_valid), 32'b111);
    checkOutput("mid_alloc_preg", 32'(bus.alloc_preg), 32'(pg(0,1,2)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/preg_alloc_ctrl.md
Name: preg_alloc_ctrl

Overview:
Controller that sequences the multi-port physical-register free-list FIFO for the rename stage. It does four things:
- Owns the FIFO's initialisation and reset.
- Grants all-or-nothing allocation groups of up to MAX_IO lanes from decode, registered into a one-deep output stage with valid/ready.
- Admits commit-side frees only when the FIFO can absorb them.
- On a pipeline flush, returns allocated-but-undelivered registers to the free list.

Parameters:
MAX_LENGTH, 64, free-list depth (number of physical registers).
PREG_BITS, 6, physical register index width; equals free-list entry width.
MAX_IO, 3, lanes per cycle for allocate and free.
CNT_BITS, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low.
req_valid  in  [MAX_IO]x1  decode lane i needs a register.
req_ready  out  1  allocation group accepted this cycle.
alloc_valid  out  1  output stage holds a granted group.
alloc_lane_valid  out  [MAX_IO]x1  lane i of the held group is valid.
alloc_preg  out  [MAX_IO]xPREG_BITS  allocated register per lane.
alloc_ready  in  1  rename consumes the held group.
free_valid  in  [MAX_IO]x1  commit lane i frees free_preg[i].
free_preg  in  [MAX_IO]xPREG_BITS  registers being freed.
free_ready  out  1  free group accepted this cycle.
flush  in  1  squash; discard the held group.
fl_rst  out  1  active-high reset to the free-list FIFO.
fl_get_en  out  [MAX_IO]x1  FIFO get enables.
fl_gotten  in  [MAX_IO]xPREG_BITS  FIFO get data, combinational, same cycle.
fl_put_en  out  [MAX_IO]x1  FIFO put enables.
fl_put  out  [MAX_IO]xPREG_BITS  FIFO put data.
fl_len  in  $clog2(MAX_LENGTH)+1  current FIFO occupancy.
stall_cnt  out  CNT_BITS  cycles with any req_valid but req_ready=0, saturating.

Behaviour:
- Reset (rst==0 at posedge):
  - state=S_INIT; stall_cnt=0.
  - Output stage: alloc_valid=0, alloc_lane_valid=0, alloc_preg=0.
  - fl_rst=1 combinationally whenever rst==0 or state==S_INIT.
  - req_ready, free_ready, fl_get_en, fl_put_en are all 0 outside S_RUN/S_RETURN as listed below.
- States:
  - S_INIT: fl_rst=1 for one cycle, then S_WARM.
  - S_WARM: one idle cycle so fl_len is valid, then S_RUN.
  - S_RUN: normal operation.
  - S_RETURN: one cycle; re-put the flushed group, then S_RUN.
- Reset mid-operation drops the output stage and returns to S_INIT. The FIFO is re-initialised to 0..MAX_LENGTH-1.
- Counts: nreq=popcount(req_valid), nfree=popcount(free_valid); both are MAX_IO-range values zero-extended to fl_len width.
- Grant in S_RUN requires all of:
  - flush==0,
  - nreq>0,
  - nreq<=fl_len,
  - (!alloc_valid || alloc_ready).
- On grant:
  - req_ready=1 and fl_get_en=req_valid, unmodified (lane i reads gotten[i]).
  - Next cycle: alloc_valid=1, alloc_lane_valid=req_valid, alloc_preg[i]=fl_gotten[i] for enabled lanes and 0 otherwise.
  - Latency is 1 cycle from request acceptance to alloc_valid.
- No partial grants. If nreq>fl_len, req_ready=0 and nothing is popped.
- Output stage:
  - Holds its contents while alloc_valid && !alloc_ready.
  - Clears alloc_valid on alloc_ready with no new grant.
  - Back-to-back grants replace it every cycle when alloc_ready stays 1.
- Frees in S_RUN:
  - free_ready=1 iff flush==0, nfree>0 and fl_len+nfree<MAX_LENGTH (strict, matching the FIFO put guard).
  - When free_ready=1, fl_put_en=free_valid and fl_put=free_preg; otherwise fl_put_en=0.
  - free_ready depends combinationally on free_valid; commit holds the group until accepted.
- Simultaneous grant and free in one cycle is allowed; the FIFO applies both.
- Flush in S_RUN:
  - req_ready=0, free_ready=0, no gets or puts that cycle.
  - If alloc_valid && !alloc_ready: latch the group into a return buffer and go to S_RETURN.
  - If alloc_valid && alloc_ready: the group is consumed; no return.
  - Either way alloc_valid clears next cycle.
- S_RETURN: fl_put_en=buffered lane valids, fl_put=buffered pregs; req_ready=0, free_ready=0; flush is ignored.
- Flush in S_INIT or S_WARM has no effect.
- stall_cnt increments in S_RUN when nreq>0 && req_ready==0, and saturates at all-ones.

Test Plan:
- Init: release rst at cycle 0 -> fl_rst high for cycle 0 only, req_ready=0 in cycles 0-1, first grant possible in cycle 2; fl_len=64.
- Grant: req_valid={1,1,1}, alloc_ready=1 in first S_RUN cycle -> next cycle alloc_valid=1, alloc_preg={0,1,2}; next group gives {3,4,5}; fl_len reads 61 then 58.
- Sparse lanes and backpressure: req_valid={1,0,1}, alloc_ready=0 for 3 cycles -> alloc_lane_valid={1,0,1}, preg lanes 0 and 2 held stable; no further pops; stall_cnt += 3 for the held requests.
- Exhaustion: drain to fl_len=2, then req 3 lanes -> req_ready=0 with no pop; req 2 lanes -> granted; fl_len=0.
- Free guard: fl_len=62, free 2 lanes -> free_ready=0; fl_len=61, free 2 -> accepted and fl_len=63 next cycle.
- Flush return: held group {7,8,9} unconsumed, flush=1 -> S_RETURN puts 7,8,9 back, fl_len +3; later reallocation order ends with 7,8,9.
